// File: rtl/fpnew_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpnew_pkg
// Description : Shared types for the FPU front end: operation/format enums,
//               status flags, the FPU request bundle and the scheduler state.
// Revision    : 1.0 - initial release
// ============================================================================
package fpnew_pkg;

  // Operands are carried at the widest supported format width.
  localparam int unsigned FP_WIDTH     = 64;
  localparam int unsigned NUM_OPERANDS = 3;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [1:0] {
    INT8  = 2'd0,
    INT16 = 2'd1,
    INT32 = 2'd2,
    INT64 = 2'd3
  } int_format_e;

  typedef enum logic [3:0] {
    FMADD    = 4'd0,
    FNMSUB   = 4'd1,
    ADD      = 4'd2,
    MUL      = 4'd3,
    DIV      = 4'd4,
    SQRT     = 4'd5,
    SGNJ     = 4'd6,
    MINMAX   = 4'd7,
    CMP      = 4'd8,
    CLASSIFY = 4'd9,
    F2F      = 4'd10,
    F2I      = 4'd11,
    I2F      = 4'd12,
    CPKAB    = 4'd13,
    CPKCD    = 4'd14
  } operation_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    DYN = 3'b111
  } roundmode_e;

  typedef struct packed {
    logic NV;  // invalid operation
    logic DZ;  // divide by zero
    logic OF;  // overflow
    logic UF;  // underflow
    logic NX;  // inexact
  } status_t;

  typedef struct packed {
    logic [NUM_OPERANDS-1:0][FP_WIDTH-1:0] operands;
    roundmode_e                            rnd_mode;
    operation_e                            op;
    logic                                  op_mod;
    fp_format_e                            src_fmt;
    fp_format_e                            dst_fmt;
    int_format_e                           int_fmt;
    logic                                  vectorial_op;
  } fpu_req_t;

  // IDLE: free arbitration. LOCKED: grant pinned until the FPU accepts.
  typedef enum logic [0:0] {
    SCHED_IDLE   = 1'b0,
    SCHED_LOCKED = 1'b1
  } sched_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpnew_credit_cnt.sv
`default_nettype none
// ============================================================================
// Module      : fpnew_credit_cnt
// Description : Per-requester in-flight operation counter. Saturates at both
//               ends; simultaneous inc and dec leave the count unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module fpnew_credit_cnt #(
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic full,
  output logic empty
);

  localparam int unsigned     CntW  = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] c_max = CntW'(MaxOutstanding);
  localparam logic [CntW-1:0] c_one = CntW'(1);

  logic [CntW-1:0] r_cnt;
  logic            w_up;
  logic            w_down;

  assign w_up   = inc & ~dec & ~full;
  assign w_down = dec & ~inc & ~empty;

  // Count register: clear dominates, then bounded step up or down.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (w_up) begin
      r_cnt <= r_cnt + c_one;
    end else if (w_down) begin
      r_cnt <= r_cnt - c_one;
    end
  end

  assign full  = (r_cnt == c_max);
  assign empty = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/fpnew_shared_sched.sv
`default_nettype none
// ============================================================================
// Module      : fpnew_shared_sched
// Description : Round-robin scheduler sharing one FPU between NumReq
//               requesters. Tags each issue with the requester index and
//               routes results back by tag; limits in-flight ops per requester.
// Revision    : 1.0 - initial release
// ============================================================================
module fpnew_shared_sched
  import fpnew_pkg::*;
#(
  parameter  int unsigned NumReq         = 2,
  parameter  int unsigned Width          = 64,
  parameter  int unsigned MaxOutstanding = 4,
  localparam int unsigned IdxW           = idx_width(NumReq)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // requester issue side
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  fpu_req_t [NumReq-1:0]   req_i,
  // requester response side
  output logic [NumReq-1:0]       rsp_valid_o,
  input  logic [NumReq-1:0]       rsp_ready_i,
  output logic [Width-1:0]        rsp_result_o,
  output status_t                 rsp_status_o,
  // FPU issue side
  output fpu_req_t                fpu_req_o,
  output logic                    fpu_in_valid_o,
  output logic [IdxW-1:0]         fpu_tag_o,
  input  logic                    fpu_in_ready_i,
  // FPU result side
  input  logic [Width-1:0]        fpu_result_i,
  input  status_t                 fpu_status_i,
  input  logic [IdxW-1:0]         fpu_tag_i,
  input  logic                    fpu_out_valid_i,
  output logic                    fpu_out_ready_o,
  // control
  input  logic                    flush_i,
  output logic                    fpu_flush_o,
  output logic                    busy_o
);

  localparam logic [IdxW-1:0] c_last_idx = IdxW'(NumReq - 1);

  sched_state_e      r_state;
  sched_state_e      w_state_next;
  logic [IdxW-1:0]   r_lock_idx;
  logic [IdxW-1:0]   w_lock_idx_next;
  logic [IdxW-1:0]   r_last_grant;

  logic [NumReq-1:0] w_full;
  logic [NumReq-1:0] w_empty;
  logic [NumReq-1:0] w_elig;
  logic [NumReq-1:0] w_tag_hit;
  logic [NumReq-1:0] w_inc;
  logic [NumReq-1:0] w_dec;

  logic [IdxW-1:0]   w_rr_idx;
  logic [IdxW-1:0]   w_rr_cand;
  logic              w_rr_found;
  logic [IdxW-1:0]   w_grant;
  logic              w_grant_ok;
  logic              w_in_valid;
  logic              w_issue;

  // Per-requester eligibility, response routing and credit tracking.
  for (genvar i = 0; i < NumReq; i++) begin : g_req
    assign w_elig[i]      = req_valid_i[i] & ~w_full[i];
    assign w_tag_hit[i]   = (fpu_tag_i == IdxW'(i));
    assign rsp_valid_o[i] = w_tag_hit[i] & fpu_out_valid_i & ~flush_i & rst_ni;
    assign w_inc[i]       = req_valid_i[i] & req_ready_o[i];
    assign w_dec[i]       = rsp_valid_o[i] & rsp_ready_i[i];

    fpnew_credit_cnt #(
      .MaxOutstanding (MaxOutstanding)
    ) u_credit_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc    (w_inc[i]),
      .dec    (w_dec[i]),
      .clr    (flush_i),
      .full   (w_full[i]),
      .empty  (w_empty[i])
    );
  end

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = r_last_grant;
    w_rr_cand  = '0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      w_rr_cand = IdxW'((32'(r_last_grant) + k) % NumReq);
      if (!w_rr_found && w_elig[w_rr_cand]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_rr_cand;
      end
    end
  end

  // Scheduler FSM next state, grant selection and issue handshake outputs.
  always_comb begin
    w_state_next    = r_state;
    w_lock_idx_next = r_lock_idx;
    w_grant         = w_rr_idx;
    w_grant_ok      = w_rr_found;
    req_ready_o     = '0;

    // A stalled request keeps the grant so the FPU input stays stable.
    if (r_state == SCHED_LOCKED) begin
      w_grant    = r_lock_idx;
      w_grant_ok = w_elig[r_lock_idx];
    end

    // Nothing may issue during a flush or while reset is held.
    w_in_valid = w_grant_ok & ~flush_i & rst_ni;
    if (w_in_valid && fpu_in_ready_i) begin
      req_ready_o[w_grant] = 1'b1;
    end

    case (r_state)
      SCHED_IDLE: begin
        if (w_in_valid && !fpu_in_ready_i) begin
          w_state_next    = SCHED_LOCKED;
          w_lock_idx_next = w_grant;
        end
      end
      SCHED_LOCKED: begin
        if (fpu_in_ready_i || flush_i) begin
          w_state_next = SCHED_IDLE;
        end
      end
      default: begin
        w_state_next = SCHED_IDLE;
      end
    endcase
  end

  assign w_issue = w_in_valid & fpu_in_ready_i;

  // FSM state and locked requester index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= SCHED_IDLE;
      r_lock_idx <= '0;
    end else begin
      r_state    <= w_state_next;
      r_lock_idx <= w_lock_idx_next;
    end
  end

  // Last grant moves only on a completed issue and survives a flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_grant <= c_last_idx;
    end else if (w_issue) begin
      r_last_grant <= w_grant;
    end
  end

  assign fpu_in_valid_o = w_in_valid;
  assign fpu_req_o      = req_i[w_grant];
  assign fpu_tag_o      = w_grant;

  // Tags with no matching requester are drained so the FPU never blocks.
  assign fpu_out_ready_o = rst_ni & ((|(w_tag_hit & rsp_ready_i)) | ~(|w_tag_hit));
  assign rsp_result_o    = fpu_result_i;
  assign rsp_status_o    = fpu_status_i;

  assign fpu_flush_o = flush_i & rst_ni;
  assign busy_o      = (|req_valid_i) | ~(&w_empty);

endmodule
`default_nettype wire

// File: tb/tb_fpnew_shared_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpnew_shared_sched
// Description : Randomized self-checking bench for fpnew_shared_sched with a
//               transaction-level model of arbitration, credits and routing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpnew_shared_sched;
  import fpnew_pkg::*;

  localparam int N_REQ = 2;
  localparam int MAXO  = 4;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  fpu_req_t [N_REQ-1:0] req;
  logic [N_REQ-1:0]   rsp_valid;
  logic [N_REQ-1:0]   rsp_ready;
  logic [63:0]        rsp_result;
  status_t            rsp_status;
  fpu_req_t           fpu_req;
  logic               fpu_in_valid;
  logic [0:0]         fpu_tag;
  logic               fpu_in_ready;
  logic [63:0]        fpu_result;
  status_t            fpu_status;
  logic [0:0]         fpu_tag_in;
  logic               fpu_out_valid;
  logic               fpu_out_ready;
  logic               flush;
  logic               fpu_flush;
  logic               busy;

  always #5 clk_i = ~clk_i;

  fpnew_shared_sched #(
    .NumReq         (N_REQ),
    .Width          (64),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_i           (req),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_result_o    (rsp_result),
    .rsp_status_o    (rsp_status),
    .fpu_req_o       (fpu_req),
    .fpu_in_valid_o  (fpu_in_valid),
    .fpu_tag_o       (fpu_tag),
    .fpu_in_ready_i  (fpu_in_ready),
    .fpu_result_i    (fpu_result),
    .fpu_status_i    (fpu_status),
    .fpu_tag_i       (fpu_tag_in),
    .fpu_out_valid_i (fpu_out_valid),
    .fpu_out_ready_o (fpu_out_ready),
    .flush_i         (flush),
    .fpu_flush_o     (fpu_flush),
    .busy_o          (busy)
  );

  // Transaction-level model state.
  int       m_last;
  bit       m_locked;
  int       m_lock_idx;
  int       m_outs [N_REQ];
  bit       pend [N_REQ];
  fpu_req_t pl [N_REQ];
  int       cyc;

  typedef struct {
    int          tag;
    logic [63:0] res;
    status_t     st;
    int          due;
  } fpu_op_t;
  fpu_op_t fq [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic fpu_req_t rand_payload();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return fpu_req_t'(r[$bits(fpu_req_t)-1:0]);
  endfunction

  task automatic model_reset();
    m_last   = N_REQ - 1;
    m_locked = 1'b0;
    m_lock_idx = 0;
    for (int i = 0; i < N_REQ; i++) m_outs[i] = 0;
    fq.delete();
  endtask

  // While reset is held every valid/ready/flush output must be low.
  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_in_valid"},  256'(fpu_in_valid),  256'(0));
    check_val({tag, "_req_ready"}, 256'(req_ready),     256'(0));
    check_val({tag, "_rsp_valid"}, 256'(rsp_valid),     256'(0));
    check_val({tag, "_out_ready"}, 256'(fpu_out_ready), 256'(0));
    check_val({tag, "_flush_o"},   256'(fpu_flush),     256'(0));
  endtask

  // One clock of randomized traffic, checked against the model.
  task automatic run_cycle(input int p_valid, input int p_in_ready, input int p_rsp_ready,
                           input int p_flush, input int lat);
    bit         elig [N_REQ];
    int         g;
    bit         gok;
    bit         exp_in_valid;
    logic [1:0] exp_rr;
    logic [1:0] exp_rv;
    bit         exp_out_ready;
    bit         any_out;

    @(negedge clk_i);
    cyc++;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pend[i]) begin
        pl[i] = rand_payload();
        if ($urandom_range(99, 0) < p_valid) pend[i] = 1'b1;
      end
      req_valid[i] = pend[i];
      req[i]       = pl[i];
      rsp_ready[i] = ($urandom_range(99, 0) < p_rsp_ready);
    end
    fpu_in_ready = ($urandom_range(99, 0) < p_in_ready);
    flush        = ($urandom_range(99, 0) < p_flush);
    if (fq.size() > 0 && fq[0].due <= cyc) begin
      fpu_out_valid = 1'b1;
      fpu_tag_in    = 1'(fq[0].tag);
      fpu_result    = fq[0].res;
      fpu_status    = fq[0].st;
    end else begin
      fpu_out_valid = 1'b0;
      fpu_tag_in    = 1'($urandom);
      fpu_result    = {$urandom, $urandom};
      fpu_status    = status_t'(5'($urandom));
    end
    #1;

    // Expected arbitration: held requester if stalled, else first eligible
    // in the rotating order after the last one served.
    for (int i = 0; i < N_REQ; i++) elig[i] = pend[i] && (m_outs[i] < MAXO);
    gok = 1'b0;
    g   = 0;
    if (m_locked) begin
      g   = m_lock_idx;
      gok = elig[g];
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        int c;
        c = (m_last + k) % N_REQ;
        if (!gok && elig[c]) begin
          gok = 1'b1;
          g   = c;
        end
      end
    end
    exp_in_valid  = gok && !flush;
    exp_rr        = (exp_in_valid && fpu_in_ready) ? 2'(1 << g) : 2'b00;
    exp_rv        = (fpu_out_valid && !flush) ? 2'(1 << fpu_tag_in) : 2'b00;
    exp_out_ready = rsp_ready[fpu_tag_in];
    any_out       = (m_outs[0] != 0) || (m_outs[1] != 0);

    check_val("in_valid", 256'(fpu_in_valid), 256'(exp_in_valid));
    if (exp_in_valid) begin
      check_val("tag", 256'(fpu_tag), 256'(g));
      check_val("fpu_req", 256'(fpu_req), 256'(pl[g]));
    end
    check_val("req_ready",  256'(req_ready),     256'(exp_rr));
    check_val("rsp_valid",  256'(rsp_valid),     256'(exp_rv));
    check_val("out_ready",  256'(fpu_out_ready), 256'(exp_out_ready));
    check_val("flush_o",    256'(fpu_flush),     256'(flush));
    check_val("busy",       256'(busy),          256'((|req_valid) || any_out));
    check_val("rsp_result", 256'(rsp_result),    256'(fpu_result));
    check_val("rsp_status", 256'(rsp_status),    256'(fpu_status));

    @(posedge clk_i);
    if (flush) begin
      for (int i = 0; i < N_REQ; i++) m_outs[i] = 0;
      m_locked = 1'b0;
      fq.delete();
    end else begin
      if (exp_in_valid && fpu_in_ready) begin
        m_outs[g]++;
        m_last  = g;
        pend[g] = 1'b0;
        fq.push_back('{tag: g, res: pl[g].operands[0] ^ pl[g].operands[1],
                       st: status_t'(pl[g].operands[2][4:0]), due: cyc + lat});
      end
      if (fpu_out_valid && exp_out_ready) begin
        if (exp_rv != 2'b00) m_outs[fpu_tag_in]--;
        void'(fq.pop_front());
      end
      if (!m_locked && exp_in_valid && !fpu_in_ready) begin
        m_locked   = 1'b1;
        m_lock_idx = g;
      end else if (m_locked && fpu_in_ready) begin
        m_locked = 1'b0;
      end
    end
  endtask

  task automatic quiet_inputs();
    req_valid     = '0;
    rsp_ready     = '0;
    fpu_in_ready  = 1'b0;
    fpu_out_valid = 1'b0;
    fpu_tag_in    = '0;
    fpu_result    = '0;
    fpu_status    = '0;
    flush         = 1'b0;
  endtask

  initial begin
    cyc    = 0;
    rst_ni = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      pend[i] = 1'b0;
      pl[i]   = rand_payload();
      req[i]  = pl[i];
    end
    quiet_inputs();
    model_reset();

    // Reset state, quiet inputs and then hostile inputs.
    repeat (2) @(negedge clk_i);
    #1;
    check_reset_outputs("rst_quiet");
    check_val("rst_busy", 256'(busy), 256'(0));
    req_valid     = 2'b11;
    flush         = 1'b1;
    fpu_out_valid = 1'b1;
    rsp_ready     = 2'b11;
    fpu_in_ready  = 1'b1;
    #1;
    check_reset_outputs("rst_driven");
    quiet_inputs();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Both requesters always valid, FPU always ready, 2-cycle echo.
    repeat (20) run_cycle(100, 100, 100, 0, 2);
    // Issue stalls to exercise the lock.
    repeat (60) run_cycle(70, 30, 80, 0, 2);
    // Slow responses so credits saturate, then drain.
    repeat (80) run_cycle(90, 90, 10, 0, 6);
    repeat (30) run_cycle(0, 100, 100, 0, 1);
    // Fully random traffic including flushes.
    repeat (2000) run_cycle($urandom_range(100, 20), $urandom_range(100, 20),
                            $urandom_range(100, 10), 3, $urandom_range(6, 1));
    // Build up work, flush, then go quiet.
    repeat (10) run_cycle(100, 100, 0, 0, 1);
    run_cycle(0, 100, 0, 100, 1);
    repeat (5) run_cycle(0, 100, 100, 0, 1);

    // Reset asserted while a request is held by the lock.
    for (int t = 0; t < 20 && !m_locked; t++) run_cycle(100, 0, 100, 0, 2);
    @(negedge clk_i);
    rst_ni        = 1'b0;
    req_valid     = 2'b11;
    fpu_in_ready  = 1'b1;
    fpu_out_valid = 1'b1;
    rsp_ready     = 2'b11;
    flush         = 1'b1;
    #1;
    check_reset_outputs("rst_midlock");
    @(negedge clk_i);
    #1;
    check_reset_outputs("rst_hold");
    model_reset();
    quiet_inputs();
    for (int i = 0; i < N_REQ; i++) pend[i] = 1'b1;
    rst_ni = 1'b1;
    // First grant after reset goes to requester 0.
    repeat (20) run_cycle(100, 100, 100, 0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
